scalar_writeback_unit: RTL
==========================

SCALAR_WRITEBACK_UNIT -- requirements
Module: scalar_writeback_unit

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 Parameter: DATA_W, default 16, result data width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port: clk  in  1  sole clock, all state updates on posedge.
REQ-005 Port: rst_n  in  1  synchronous active-low reset.
REQ-006 Port: alu_valid / alu_ready  in / out  1 / 1  ALU result handshake.
REQ-007 Port: alu_dest / alu_data  in  3 / DATA_W  ALU destination register and value.
REQ-008 Port: mem_valid / mem_ready  in / out  1 / 1  load result handshake.
REQ-009 Port: mem_dest / mem_data  in  3 / DATA_W  load destination register and value.
REQ-010 Port: stall  in  1  register-file write port frozen; no pop.
REQ-011 Port: WE  out  1  register-file write enable for registers 0-6.
REQ-012 Port: destination_register / WD  out  3 / DATA_W  register-file write address and data.
REQ-013 Port: r7_we / r7_wd  out  1 / DATA_W  write to externally held R7.
REQ-014 Port: pending  out  8  bit r set while any queued entry targets register r.
REQ-015 Port: count  out  clog2(DEPTH)+1  occupied FIFO entries.

Function
REQ-016 Results are queued in a DEPTH-entry FIFO of {dest, data}; at most one enqueue per cycle.
REQ-017 mem_ready = !full; alu_ready = !full && !mem_valid (load has priority).
REQ-018 Enqueue at posedge when (mem_valid && mem_ready) or (alu_valid && alu_ready); the entry is taken from the mem source if it fires, otherwise from the alu source.
REQ-019 Ready is computed from full only; a pop in the same cycle does not make a full FIFO ready.
REQ-020 Outputs are combinational from the FIFO head: when !empty, head.dest != 7 -> WE=1, destination_register=head.dest, WD=head.data, r7_we=0.
REQ-021 Head with dest == 7 -> r7_we=1, r7_wd=head.data, WE=0; register 7 in the file is never written.
REQ-022 When empty: WE=0, r7_we=0, destination_register=0, WD=0, r7_wd=0.
REQ-023 Pop at posedge when !empty && !stall; while stall=1, head, WE/r7_we and all outputs hold steady.
REQ-024 Latency: a result accepted at edge N into an empty FIFO is presented (WE or r7_we high) in cycle N..N+1 and popped at edge N+1 if not stalled.
REQ-025 Simultaneous enqueue and pop: count unchanged, ordering preserved (strict FIFO, no reordering or merging).
REQ-026 Pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-027 Repeated writes to the same register are all issued in arrival order.
REQ-028 pending[r] = OR over valid entries of (dest==r), including the head; cleared the cycle after the last such entry pops.

Reset
REQ-029 rst_n=0 at posedge: count=0, pointers=0, pending=0, WE=0, r7_we=0, all data outputs 0.
REQ-030 Reset mid-operation discards all queued entries; none are written afterwards.
REQ-031 During reset, alu_ready and mem_ready are 0.

Structure
REQ-032 Package scalar_wb_pkg holds DATA_W default, REG_ADDR_W=3, R7_ADDR=3'b111 and typedef struct wb_entry_t {dest, data}.
REQ-033 FIFO storage/pointers live in one sub-module, wb_fifo (push/pop/full/empty/count, entry array exposed for pending).

Verification
REQ-034 Single ALU result dest=3, data=16'hBEEF into empty FIFO -> next cycle WE=1, destination_register=3, WD=16'hBEEF for exactly one cycle; pending[3] high for that cycle only.
REQ-035 alu_valid and mem_valid both high (alu dest=1 data=1, mem dest=2 data=2) -> alu_ready=0, mem entry issued first, then alu entry.
REQ-036 Result dest=7 data=16'h1234 -> r7_we=1, r7_wd=16'h1234, WE=0.
REQ-037 stall=1, push 5 results with DEPTH=4 -> count reaches 4, both readies 0, 5th held by source; release stall -> 5 writes in order, count returns to 0.
REQ-038 Queue 3 entries, assert rst_n=0 one cycle -> count=0, pending=0, no WE after reset.
REQ-039 Continuous one-per-cycle pushes, stall=0 -> count stays 1, one write per cycle, pointers wrap past DEPTH without loss.

Source files
------------

// File: rtl/scalar_wb_pkg.sv
// Shared types and constants for the scalar writeback path.
package scalar_wb_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int REG_ADDR_W = 3;
    localparam logic [REG_ADDR_W-1:0] R7_ADDR = 3'b111;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Result FIFO: {dest, data} storage, wrapping pointers, occupancy and a
// per-slot valid mask so the owner can derive register-pending bits.
module wb_fifo
    import scalar_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push_i,
    input  logic [REG_ADDR_W-1:0]                 push_dest_i,
    input  logic [DATA_W-1:0]                     push_data_i,
    input  logic                                  pop_i,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic [AW:0]                           count_o,
    output logic [REG_ADDR_W-1:0]                 head_dest_o,
    output logic [DATA_W-1:0]                     head_data_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      ent_dest_o,
    output logic [DEPTH-1:0]                      ent_vld_o
);
    logic [REG_ADDR_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]           count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: every read is qualified by the valid mask or empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            dest_q[wr_q] <= push_dest_i;
            data_q[wr_q] <= push_data_i;
        end
    end

    assign count_o     = count_q;
    assign head_dest_o = dest_q[rd_q];
    assign head_data_o = data_q[rd_q];

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [AW-1:0] off;
        assign off            = AW'(gi) - rd_q;
        assign ent_vld_o[gi]  = ({1'b0, off} < count_q);
        assign ent_dest_o[gi] = dest_q[gi];
    end
endmodule

// File: rtl/scalar_writeback_unit.sv
// Merges ALU and load results into one ordered stream of register-file
// writes; R7 lives outside the file and gets its own write strobe.
module scalar_writeback_unit
    import scalar_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [2:0]              alu_dest,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [2:0]              mem_dest,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    stall,
    output logic                    WE,
    output logic [2:0]              destination_register,
    output logic [DATA_W-1:0]       WD,
    output logic                    r7_we,
    output logic [DATA_W-1:0]       r7_wd,
    output logic [7:0]              pending,
    output logic [$clog2(DEPTH):0]  count
);
    logic                             full, empty, push, pop, head_is_r7;
    logic [REG_ADDR_W-1:0]            push_dest, head_dest;
    logic [DATA_W-1:0]                push_data, head_data;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_dest;
    logic [DEPTH-1:0]                 ent_vld;

    // Loads win arbitration; a same-cycle pop never frees a full queue.
    assign mem_ready = rst_n && !full;
    assign alu_ready = rst_n && !full && !mem_valid;
    assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_dest = mem_valid ? mem_dest : alu_dest;
    assign push_data = mem_valid ? mem_data : alu_data;
    assign pop       = !empty && !stall;

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_dest_i (push_dest),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .head_dest_o (head_dest),
        .head_data_o (head_data),
        .ent_dest_o  (ent_dest),
        .ent_vld_o   (ent_vld)
    );

    assign head_is_r7           = (head_dest == R7_ADDR);
    assign WE                   = !empty && !head_is_r7;
    assign destination_register = WE ? head_dest : '0;
    assign WD                   = WE ? head_data : '0;
    assign r7_we                = !empty && head_is_r7;
    assign r7_wd                = r7_we ? head_data : '0;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld[i]) pending[ent_dest[i]] = 1'b1;
    end
endmodule
